pwm_axi_slave: RTL and testbench
================================

PWM_AXI_SLAVE -- requirements
Module: pwm_axi_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (four 32-bit registers).
REQ-003 SHALL have parameter C_PWM_CNT_WIDTH, default 32, PWM counter width.
REQ-004 S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 S_AXI_AWADDR in ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-007 S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-008 S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-009 S_AXI_ARADDR in ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-010 S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-011 pwm_out  out  1  registered PWM waveform.

Function
REQ-012 Register map (byte offset, addr[3:2]): 0x0 CTRL, 0x4 PERIOD, 0x8 DUTY, 0xC SCRATCH; all 32-bit read/write, full readback of written value; addr[1:0] ignored.
REQ-013 CTRL bit0 = enable, bit1 = polarity (1 = active-low output); other CTRL bits stored and read back, no effect.
REQ-014 Write accept: AWREADY and WREADY SHALL pulse high together for exactly one cycle when AWVALID && WVALID && !BVALID && !(AWREADY); no acceptance with only one of AWVALID/WVALID high.
REQ-015 Register update in the accept cycle edge; new value readable from the next cycle; each byte lane written only if its WSTRB bit is set.
REQ-016 BVALID SHALL rise the cycle after accept, BRESP = 2'b00 (OKAY), held until BREADY sampled high; no new write accepted while BVALID high.
REQ-017 Read accept: ARREADY pulses one cycle when ARVALID && !RVALID && !ARREADY; RVALID rises next cycle with RDATA of addressed register, RRESP = OKAY, RDATA/RVALID stable until RREADY.
REQ-018 Read and write accepted in the same cycle to the same register: read SHALL return the pre-write value.
REQ-019 PWM counter counts 0..PERIOD_s-1 then wraps to 0, where PERIOD_s/DUTY_s are shadow copies.
REQ-020 Shadow copies SHALL load from PERIOD/DUTY at counter wrap and on the cycle enable transitions 0->1; mid-period register writes take effect only at next wrap.
REQ-021 Active level when enabled: counter < DUTY_s; pwm_out = active XOR polarity, registered (1-cycle latency from counter).
REQ-022 Boundaries: DUTY_s = 0 -> never active; DUTY_s >= PERIOD_s -> always active; PERIOD_s = 0 -> counter held 0, output inactive.
REQ-023 enable = 0: counter held 0, pwm_out = polarity (inactive level).

Reset
REQ-024 While S_AXI_ARESETN low at a clock edge: all registers, shadows and counter = 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0; pwm_out = 0.
REQ-025 Reset mid-transaction SHALL abort it; no B or R response issued for transactions accepted before reset.

Structure
REQ-026 Shared package pwm_ip_pkg SHALL hold register offsets, CTRL bit indices and AXI RESP_OKAY constant.
REQ-027 PWM counter/compare/shadow logic SHALL be sub-module pwm_gen; AXI register interface stays in pwm_axi_slave.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to offsets 0x0,0x4,0x8,0xC, read back all four -> exact values, BRESP/RRESP = OKAY.
REQ-029 Write 0xAABBCCDD to SCRATCH with WSTRB=4'b0101 after 0x0 -> readback 0x00BB00DD.
REQ-030 PERIOD=10, DUTY=3, CTRL=1 -> pwm_out high 3 cycles, low 7, repeating; CTRL=3 -> inverted.
REQ-031 Mid-period write DUTY=7 -> current period still 3 high; next period 7 high; DUTY=12 -> constantly high; DUTY=0 -> constantly low.
REQ-032 AWVALID asserted 5 cycles before WVALID, BREADY held low 4 cycles -> no accept until WVALID, BVALID held, second write stalled until B completes.
REQ-033 Reset asserted with BVALID and RVALID high -> both drop after the reset edge, pwm_out = 0, all registers read 0 afterwards.

Source files
------------

// File: rtl/pwm_ip_pkg.sv
// Shared constants for the PWM AXI4-Lite peripheral.
// Register word indices (addr[3:2]), CTRL bit positions, AXI response codes.
package pwm_ip_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DUTY    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_axi_slave_pwm_gen.sv
// PWM generator: shadowed period/duty, free-running counter, registered output.
// Ports: clk, rst_n (sync), enable, polarity, period, duty -> pwm_out.
module pwm_gen #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         polarity,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  output logic         pwm_out
);

  logic [W-1:0] cnt;
  logic [W-1:0] period_s;
  logic [W-1:0] duty_s;
  logic [W-1:0] p_eff;
  logic [W-1:0] d_eff;
  logic         en_q;
  logic         rise;
  logic         wrap;
  logic         active;

  // On the enable rising cycle the fresh register values are used
  // directly so the first period already honours them.
  always_comb begin
    rise   = enable & ~en_q;
    p_eff  = rise ? period : period_s;
    d_eff  = rise ? duty : duty_s;
    wrap   = (p_eff == '0) || (cnt >= p_eff - W'(1));
    active = (p_eff != '0) && (cnt < d_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      period_s <= '0;
      duty_s   <= '0;
      en_q     <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        cnt     <= '0;
        pwm_out <= polarity;
      end else begin
        cnt     <= wrap ? '0 : cnt + W'(1);
        pwm_out <= active ^ polarity;
        if (rise || wrap) begin
          period_s <= period;
          duty_s   <= duty;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_axi_slave.sv
// AXI4-Lite slave with four 32-bit registers driving a PWM generator.
// Ports: AXI4-Lite AW/W/B/AR/R channels on S_AXI_ACLK, pwm_out.
module pwm_axi_slave
  import pwm_ip_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_PWM_CNT_WIDTH    = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out
);

  logic [31:0] regs [4];
  logic        awready;
  logic        arready;
  logic        bvalid;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wr_hs;
  logic        rd_hs;
  logic        unused_ok;

  assign wr_hs = awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs = arready & S_AXI_ARVALID;

  // Read data samples the registers before this edge's write lands,
  // so a same-cycle read of a written register returns the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      awready <= 1'b0;
      arready <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      awready <= S_AXI_AWVALID & S_AXI_WVALID
               & ~bvalid & ~awready;
      if (wr_hs) begin
        regs[S_AXI_AWADDR[3:2]] <= apply_strb(
          regs[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);
        bvalid <= 1'b1;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      arready <= S_AXI_ARVALID & ~rvalid & ~arready;
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= regs[S_AXI_ARADDR[3:2]];
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = awready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  pwm_gen #(
    .W(C_PWM_CNT_WIDTH)
  ) u_pwm_gen (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .enable   (regs[REG_CTRL][CTRL_EN]),
    .polarity (regs[REG_CTRL][CTRL_POL]),
    .period   (regs[REG_PERIOD][C_PWM_CNT_WIDTH-1:0]),
    .duty     (regs[REG_DUTY][C_PWM_CNT_WIDTH-1:0]),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_pwm_axi_slave.sv
// Self-checking bench for pwm_axi_slave.
// Scoreboarded register reads plus PWM waveform run-length checks.
module tb_pwm_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        pwm_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  pwm_axi_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pwm_out       (pwm_out)
  );

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    n_checks++;
    if (!awready) begin
      n_fail++;
      $display("FAIL wr_accept a=%h: awready=%b required 1", a, awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_bresp a=%h: bvalid=%b bresp=%b required 1/00",
               a, bvalid, bresp);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read_expect(input logic [3:0] a, input logic [31:0] e);
    int n;
    logic [31:0] got, want;
    exp_q.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    want = exp_q.pop_front();
    got  = rdata;
    n_checks++;
    if (rvalid !== 1'b1 || got !== want || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL rd a=%h: rvalid=%b data=%h rresp=%b required 1/%h/00",
               a, rvalid, got, rresp, want);
    end
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Length of the next complete run of pwm_out at level lvl.
  task automatic run_len(input logic lvl, output int len);
    int n;
    n = 0;
    while (pwm_out === lvl && n < 64) begin @(negedge clk); n++; end
    n = 0;
    while (pwm_out !== lvl && n < 64) begin @(negedge clk); n++; end
    len = 0;
    while (pwm_out === lvl && len < 64) begin @(negedge clk); len++; end
  endtask

  task automatic check_run(input logic lvl, input int want, input string nm);
    int len;
    run_len(lvl, len);
    n_checks++;
    if (len !== want) begin
      n_fail++;
      $display("FAIL %s: run of %b lasted %0d required %0d",
               nm, lvl, len, want);
    end
  endtask

  task automatic check_const(input logic lvl, input string nm);
    int bad;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (pwm_out !== lvl) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d cycles differed from level %b required 0",
               nm, bad, lvl);
    end
  endtask

  task automatic test_reset;
    logic [8:0] flags;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    flags = {awready, wready, bvalid, arready, rvalid,
             bresp, rresp[0], pwm_out};
    n_checks++;
    if (flags !== 9'd0 || rdata !== 32'd0 || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_out: flags=%b rdata=%h required 0/0",
               flags, rdata);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) axi_read_expect(4'(i * 4), 32'd0);
  endtask

  task automatic test_regs;
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read_expect(4'h0, 32'h1);
    axi_read_expect(4'h4, 32'h2);
    axi_read_expect(4'h8, 32'h3);
    axi_read_expect(4'hD, 32'h4);
    axi_write(4'hC, 32'h0, 4'hF);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101);
    axi_read_expect(4'hC, 32'h00BB00DD);
  endtask

  task automatic test_pwm_basic;
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    check_run(1'b1, 3, "pwm_high");
    check_run(1'b0, 7, "pwm_low");
    axi_write(4'h0, 32'h3, 4'hF);
    check_run(1'b0, 3, "inv_active");
    check_run(1'b1, 7, "inv_idle");
    axi_write(4'h0, 32'h1, 4'hF);
  endtask

  task automatic test_mid_period;
    int n;
    int len;
    n = 0;
    while (pwm_out !== 1'b0 && n < 64) begin @(negedge clk); n++; end
    n = 0;
    while (pwm_out !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    len = 0;
    fork
      axi_write(4'h8, 32'd7, 4'hF);
      while (pwm_out === 1'b1 && len < 64) begin
        @(negedge clk); len++;
      end
    join
    n_checks++;
    if (len !== 3) begin
      n_fail++;
      $display("FAIL mid_cur: run lasted %0d required 3", len);
    end
    check_run(1'b1, 7, "mid_next");
    axi_write(4'h8, 32'd0, 4'hF);
    repeat (22) @(negedge clk);
    check_const(1'b0, "duty_zero");
    axi_write(4'h8, 32'd12, 4'hF);
    repeat (22) @(negedge clk);
    check_const(1'b1, "duty_over");
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    awaddr = 4'hC; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    wdata = 32'h55; wstrb = 4'hF;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b0) begin
        n_fail++;
        $display("FAIL aw_only: awready=%b required 0", awready);
      end
    end
    wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h66;
    repeat (4) begin
      n_checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_fail++;
        $display("FAIL b_hold: bvalid=%b awready=%b required 1/0",
                 bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    n_checks++;
    if (awready !== 1'b1) begin
      n_fail++;
      $display("FAIL second_wr: awready=%b required 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bready = 1'b0;
    axi_read_expect(4'hC, 32'h66);
  endtask

  task automatic test_reset_midflight;
    int n;
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid && rvalid) && n < 50);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_checks++;
    if ({bvalid, rvalid, pwm_out} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset: b/r/pwm=%b required 111",
               {bvalid, rvalid, pwm_out});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bvalid, rvalid, pwm_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL in_reset: b/r/pwm=%b required 000",
               {bvalid, rvalid, pwm_out});
    end
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({bvalid, rvalid, pwm_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL post_reset: b/r/pwm=%b required 000",
                 {bvalid, rvalid, pwm_out});
      end
    end
    for (int i = 0; i < 4; i++) axi_read_expect(4'(i * 4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_regs();
    test_pwm_basic();
    test_mid_period();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
